// File: rtl/frame_parity_gen.sv
// Streaming frame parity generator: folds the parity of every accepted beat of a frame and emits one
// registered result (bit, beat count, overflow) per frame. Define PARITY_CHECK_EN to add exp_par/par_err.
module frame_parity_gen #(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16,
    localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              par_valid,
    input  logic              par_ready,
    output logic              par_bit,
    output logic [CNT_W-1:0]  par_beats,
    output logic              par_ovf
`ifdef PARITY_CHECK_EN
    ,
    input  logic              exp_par,
    output logic              par_err
`endif
);

    // The internal counter needs one extra code above MAX_BEATS to flag overflow without wrapping.
    localparam int               SAT_W   = $clog2(MAX_BEATS + 2);
    localparam logic [SAT_W-1:0] SAT_MAX = SAT_W'(MAX_BEATS + 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_acc;
    logic             r_mode;
    logic [SAT_W-1:0] r_count;
    logic             r_par_valid;
    logic             r_par_bit;
    logic [CNT_W-1:0] r_par_beats;
    logic             r_par_ovf;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_done;
    logic             w_mode;
    logic             w_acc_nxt;
    logic             w_par_bit;
    logic [SAT_W-1:0] w_count_inc;
    logic             w_ovf;
    logic [CNT_W-1:0] w_beats;

    assign w_in_ready = !r_par_valid || par_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_done     = w_accept && in_last;

    // The first beat of a frame uses the live mode; later beats use the copy latched on that first beat.
    assign w_mode    = (r_state == IDLE) ? odd_mode : r_mode;
    assign w_acc_nxt = r_acc ^ (^in_data);
    assign w_par_bit = w_acc_nxt ^ w_mode;

    always_comb begin
        w_count_inc = (r_count == SAT_MAX) ? r_count : r_count + SAT_W'(1);
        w_ovf       = (w_count_inc > SAT_W'(MAX_BEATS));
        w_beats     = w_ovf ? CNT_W'(MAX_BEATS) : CNT_W'(w_count_inc);
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && !in_last) w_state_nxt = ACCUM;
            ACCUM:   if (w_done)               w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= 1'b0;
            r_mode  <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            if (r_state == IDLE) r_mode <= odd_mode;
            if (in_last) begin
                r_acc   <= 1'b0;
                r_count <= '0;
            end else begin
                r_acc   <= w_acc_nxt;
                r_count <= w_count_inc;
            end
        end
    end

    // Result register: a new last beat reloads it even in the handshake cycle, giving full-rate 1-beat frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_valid <= 1'b0;
            r_par_bit   <= 1'b0;
            r_par_beats <= '0;
            r_par_ovf   <= 1'b0;
        end else if (w_done) begin
            r_par_valid <= 1'b1;
            r_par_bit   <= w_par_bit;
            r_par_beats <= w_beats;
            r_par_ovf   <= w_ovf;
        end else if (r_par_valid && par_ready) begin
            r_par_valid <= 1'b0;
        end
    end

`ifdef PARITY_CHECK_EN
    logic r_par_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else if (w_done) begin
            r_par_err <= w_par_bit ^ exp_par;
        end
    end

    assign par_err = r_par_err;
`endif

    assign in_ready  = w_in_ready;
    assign par_valid = r_par_valid;
    assign par_bit   = r_par_bit;
    assign par_beats = r_par_beats;
    assign par_ovf   = r_par_ovf;

endmodule
